// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate prescaler plus horizontal/vertical counters
// with registered sync, active, coordinate and line/frame strobe outputs.
module vga_timing_gen #(
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int H_ACT   = 640,
    parameter int H_FP    = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int V_ACT   = 480,
    parameter int V_FP    = 10,
    parameter int H_POL   = 0,
    parameter int V_POL   = 0,
    parameter int CLK_DIV = 2,
    parameter int CW      = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          pix_ce,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          hactive,
    output logic          vactive,
    output logic          active,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic          line_start,
    output logic          frame_start
);
    localparam int   H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int   V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int   DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic HP      = (H_POL != 0);
    localparam logic VP      = (V_POL != 0);

    if (H_SYNC < 1 || H_BP < 1 || H_ACT < 1 || H_FP < 1) begin : g_bad_h
        $error("vga_timing_gen: every horizontal region must be >= 1");
    end
    if (V_SYNC < 1 || V_BP < 1 || V_ACT < 1 || V_FP < 1) begin : g_bad_v
        $error("vga_timing_gen: every vertical region must be >= 1");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be >= 1");
    end
    if (H_TOTAL >= (1 << CW) || V_TOTAL >= (1 << CW)) begin : g_bad_cw
        $error("vga_timing_gen: raster totals do not fit in CW bits");
    end

    logic [DW-1:0] div, div_n;
    logic          tick, hwrap, vwrap;
    logic [CW-1:0] h_n, v_n, px_n, py_n;
    logic          hs_n, vs_n, ha_n, va_n;

    // Decode from the next-state counters so every output lines up with hcount/vcount.
    always_comb begin
        tick  = en && (div == DW'(CLK_DIV - 1));
        div_n = tick ? '0 : (en ? div + 1'b1 : div);
        hwrap = tick && (hcount == CW'(H_TOTAL - 1));
        vwrap = hwrap && (vcount == CW'(V_TOTAL - 1));
        h_n   = hcount;
        v_n   = vcount;
        if (tick) h_n = hwrap ? '0 : hcount + 1'b1;
        if (hwrap) v_n = vwrap ? '0 : vcount + 1'b1;
        hs_n  = (h_n < CW'(H_SYNC)) ? HP : ~HP;
        vs_n  = (v_n < CW'(V_SYNC)) ? VP : ~VP;
        ha_n  = (h_n >= CW'(H_SYNC + H_BP)) && (h_n < CW'(H_SYNC + H_BP + H_ACT));
        va_n  = (v_n >= CW'(V_SYNC + V_BP)) && (v_n < CW'(V_SYNC + V_BP + V_ACT));
        px_n  = (ha_n && va_n) ? h_n - CW'(H_SYNC + H_BP) : '0;
        py_n  = va_n ? v_n - CW'(V_SYNC + V_BP) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div         <= '0;
            hcount      <= '0;
            vcount      <= '0;
            pix_ce      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= HP;
            vsync       <= VP;
            hactive     <= 1'b0;
            vactive     <= 1'b0;
            active      <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
        end else if (en) begin
            div         <= div_n;
            hcount      <= h_n;
            vcount      <= v_n;
            pix_ce      <= (div_n == DW'(CLK_DIV - 1));
            line_start  <= hwrap;
            frame_start <= vwrap;
            hsync       <= hs_n;
            vsync       <= vs_n;
            hactive     <= ha_n;
            vactive     <= va_n;
            active      <= ha_n && va_n;
            pix_x       <= px_n;
            pix_y       <= py_n;
        end else begin
            pix_ce      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a tiny raster: a closed-form model derived from the
// count of enabled clock edges predicts every output; a monitor compares once per clk.
module tb_vga_timing_gen;
    localparam int HS = 2, HB = 3, HA = 4, HF = 1;
    localparam int VS = 1, VB = 1, VA = 2, VF = 1;
    localparam int HPOL = 1, VPOL = 0, DIV = 2, CW = 11;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;

    logic clk = 0, rst = 1, en = 0;
    logic pix_ce, hsync, vsync, hactive, vactive, active, line_start, frame_start;
    logic [CW-1:0] hcount, vcount, pix_x, pix_y;

    vga_timing_gen #(
        .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
        .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF),
        .H_POL(HPOL), .V_POL(VPOL), .CLK_DIV(DIV), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .pix_ce(pix_ce),
        .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
        .hactive(hactive), .vactive(vactive), .active(active),
        .pix_x(pix_x), .pix_y(pix_y),
        .line_start(line_start), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h, v, px, py;
        bit hs, vs, ha, va, act, ce, ls, fs;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_pass = 0;
    int unsigned ecnt = 0;

    // Position is simply (enabled edges / DIV) modulo the frame size.
    function automatic exp_t model(int unsigned e, bit ev);
        exp_t r;
        int p;
        p     = int'((e / DIV) % (HT * VT));
        r.h   = p % HT;
        r.v   = p / HT;
        r.ha  = (r.h >= HS + HB) && (r.h < HS + HB + HA);
        r.va  = (r.v >= VS + VB) && (r.v < VS + VB + VA);
        r.act = r.ha && r.va;
        r.px  = r.act ? r.h - (HS + HB) : 0;
        r.py  = r.va ? r.v - (VS + VB) : 0;
        r.hs  = (r.h < HS) ? (HPOL != 0) : (HPOL == 0);
        r.vs  = (r.v < VS) ? (VPOL != 0) : (VPOL == 0);
        r.ce  = ev && (e % DIV == DIV - 1);
        r.ls  = ev && (e % DIV == 0) && (r.h == 0);
        r.fs  = r.ls && (r.v == 0);
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            ecnt = 0;
            q.push_back(model(0, 1'b0));
        end else if (en) begin
            ecnt++;
            q.push_back(model(ecnt, 1'b1));
        end else begin
            q.push_back(model(ecnt, 1'b0));
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("hcount", int'(hcount), e.h);
                chk("vcount", int'(vcount), e.v);
                chk("pix_x", int'(pix_x), e.px);
                chk("pix_y", int'(pix_y), e.py);
                chk("hsync", int'(hsync), int'(e.hs));
                chk("vsync", int'(vsync), int'(e.vs));
                chk("hactive", int'(hactive), int'(e.ha));
                chk("vactive", int'(vactive), int'(e.va));
                chk("active", int'(active), int'(e.act));
                chk("pix_ce", int'(pix_ce), int'(e.ce));
                chk("line_start", int'(line_start), int'(e.ls));
                chk("frame_start", int'(frame_start), int'(e.fs));
            end
        end
    end

    task automatic run_random(input int cycles, input int pct_on);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            en = ($urandom_range(0, 99) < pct_on);
        end
    endtask

    task automatic wait_pos(input int hv, input int vv, input string name);
        bit found = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            en = 1;
            if (int'(hcount) == hv && (vv < 0 || int'(vcount) == vv)) found = 1;
        end
        chk(name, int'(found), 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 0;
        en  = 1;
        run_random(250, 100);
        run_random(400, 75);

        // Hold en low for 7 clk with the raster parked at hcount 5.
        wait_pos(5, -1, "wait_hcount5");
        en = 0;
        repeat (7) @(negedge clk);
        en = 1;
        run_random(300, 85);

        // Asynchronous reset mid-frame, checked before any clock edge.
        wait_pos(7, 3, "wait_midframe");
        #1 rst = 1;
        #1;
        chk("async_rst hcount", int'(hcount), 0);
        chk("async_rst vcount", int'(vcount), 0);
        chk("async_rst hsync", int'(hsync), HPOL);
        chk("async_rst vsync", int'(vsync), VPOL);
        chk("async_rst active", int'(active), 0);
        chk("async_rst hactive", int'(hactive), 0);
        chk("async_rst pix_x", int'(pix_x), 0);
        chk("async_rst pix_ce", int'(pix_ce), 0);
        chk("async_rst strobes", int'({line_start, frame_start}), 0);
        repeat (2) @(negedge clk);
        rst = 0;
        run_random(300, 100);
        run_random(500, 60);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
